// File: rtl/mux2_4_pkg.sv
// Shared defaults for the mux2_4_new slice: data width, counter width and the
// default data word type.
package mux2_4_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int CNT_W_DEF = 8;

    typedef logic [WIDTH_DEF-1:0] data_t;

endpackage : mux2_4_pkg

// File: rtl/mux2_cell.sv
// Purely combinational WIDTH-bit 2:1 selector; an unknown select yields all-X
// in simulation so that a bad select propagates instead of being masked.
module mux2_cell
    import mux2_4_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             S,
    output logic [WIDTH-1:0] res
);

    always_comb begin
        res = 'x;
        case (S)
            1'b0:    res = in0;
            1'b1:    res = in1;
            default: res = 'x;
        endcase
    end

endmodule : mux2_cell

// File: rtl/mux2_4_new.sv
// 2:1 mux with a registered copy of the result and select, plus a saturating
// count of select transitions. en is a plain load enable, never a clock gate.
module mux2_4_new
    import mux2_4_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             S,
    input  logic             en,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] res_q,
    output logic             sel_q,
    output logic [CNT_W-1:0] toggle_cnt
);

    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] res_q_q;
    logic             sel_d;
    logic             sel_q_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    mux2_cell #(
        .WIDTH (WIDTH)
    ) u_cell (
        .in0 (in0),
        .in1 (in1),
        .S   (S),
        .res (res)
    );

    // Compare against the registered select, so the first S=1 after reset counts.
    always_comb begin
        res_d = res_q_q;
        sel_d = sel_q_q;
        cnt_d = cnt_q;
        if (en) begin
            res_d = res;
            sel_d = S;
            if ((S != sel_q_q) && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q_q <= '0;
            sel_q_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            res_q_q <= res_d;
            sel_q_q <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign res_q      = res_q_q;
    assign sel_q      = sel_q_q;
    assign toggle_cnt = cnt_q;

endmodule : mux2_4_new

// File: tb/tb_mux2_4_new.sv
// Randomised and directed bench for mux2_4_new; a CNT_W=8 and a CNT_W=2 instance
// share stimulus and are compared against a transaction-level reference model.
module tb_mux2_4_new;

    logic       clk;
    logic       rst_n;
    logic [3:0] in0;
    logic [3:0] in1;
    logic       S;
    logic       en;
    logic [3:0] res;
    logic [3:0] res_q;
    logic       sel_q;
    logic [7:0] toggle_cnt;
    logic [3:0] res2;
    logic [3:0] res_q2;
    logic       sel_q2;
    logic [1:0] toggle_cnt2;

    int checks   = 0;
    int failures = 0;

    // reference model state: unbounded toggle count, saturation applied on compare
    logic [3:0] m_res_q;
    logic       m_sel;
    int         m_toggles;

    mux2_4_new #(.WIDTH(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in0        (in0),
        .in1        (in1),
        .S          (S),
        .en         (en),
        .res        (res),
        .res_q      (res_q),
        .sel_q      (sel_q),
        .toggle_cnt (toggle_cnt)
    );

    mux2_4_new #(.WIDTH(4), .CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .in0        (in0),
        .in1        (in1),
        .S          (S),
        .en         (en),
        .res        (res2),
        .res_q      (res_q2),
        .sel_q      (sel_q2),
        .toggle_cnt (toggle_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic check_regs(input string tag);
        chk({tag, ".res_q"},  32'(res_q),       32'(m_res_q));
        chk({tag, ".sel_q"},  32'(sel_q),       32'(m_sel));
        chk({tag, ".cnt"},    32'(toggle_cnt),  32'(sat(m_toggles, 255)));
        chk({tag, ".res_q2"}, 32'(res_q2),      32'(m_res_q));
        chk({tag, ".cnt2"},   32'(toggle_cnt2), 32'(sat(m_toggles, 3)));
    endtask

    // Apply one input vector between edges, check the mux at once, then clock it.
    task automatic step(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic s, input logic e);
        logic [3:0] want;
        @(negedge clk);
        in0 = a;
        in1 = b;
        S   = s;
        en  = e;
        want = s ? b : a;
        #1;
        chk({tag, ".res"},  32'(res),  32'(want));
        chk({tag, ".res2"}, 32'(res2), 32'(want));
        @(posedge clk);
        if (e && rst_n) begin
            if (s != m_sel) m_toggles++;
            m_res_q = want;
            m_sel   = s;
        end
        #1;
        check_regs(tag);
    endtask

    task automatic mid_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        m_res_q   = '0;
        m_sel     = 1'b0;
        m_toggles = 0;
        #1;
        check_regs(tag);
        chk({tag, ".res_live"}, 32'(res), 32'(S ? in1 : in0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        in0 = 4'd8;
        in1 = 4'd4;
        S   = 1'b0;
        en  = 1'b1;
        m_res_q   = '0;
        m_sel     = 1'b0;
        m_toggles = 0;
        #3;
        check_regs("reset");
        chk("reset.res_live", 32'(res), 32'd8);
        @(negedge clk);
        rst_n = 1'b1;

        // combinational select sequence
        step("comb0", 4'd8, 4'd4, 1'b0, 1'b1);
        step("comb1", 4'd7, 4'd3, 1'b0, 1'b1);
        step("comb2", 4'd6, 4'd2, 1'b1, 1'b1);
        step("comb3", 4'd5, 4'd1, 1'b1, 1'b1);
        chk("comb.cnt_after", 32'(toggle_cnt), 32'd1);

        // alternating select, one toggle per change
        step("alt0", 4'd4, 4'd5, 1'b1, 1'b1);
        step("alt1", 4'd3, 4'd6, 1'b0, 1'b1);
        step("alt2", 4'd2, 4'd7, 1'b1, 1'b1);
        step("alt3", 4'd1, 4'd8, 1'b0, 1'b1);
        chk("alt.cnt_after", 32'(toggle_cnt), 32'd4);

        // latency: select and data change together
        step("lat0", 4'd8, 4'd0, 1'b0, 1'b1);
        step("lat1", 4'd8, 4'd4, 1'b1, 1'b1);
        chk("lat.res_q", 32'(res_q), 32'd4);
        chk("lat.sel_q", 32'(sel_q), 32'd1);

        // hold with en low
        step("hold0", 4'd9, 4'd2, 1'b0, 1'b0);
        step("hold1", 4'd3, 4'd11, 1'b1, 1'b0);
        step("hold2", 4'd14, 4'd6, 1'b0, 1'b0);
        chk("hold.cnt", 32'(toggle_cnt), 32'd5);
        chk("hold.res_q", 32'(res_q), 32'd4);

        // asynchronous reset between edges with toggle_cnt at 5
        mid_reset("midrst");
        chk("midrst.cnt_zero", 32'(toggle_cnt), 32'd0);

        // data-only changes leave the count alone
        step("data0", 4'd1, 4'd2, 1'b0, 1'b1);
        step("data1", 4'd15, 4'd12, 1'b0, 1'b1);

        // saturation: 5 toggles after reset
        for (int i = 0; i < 5; i++) begin
            step("sat", 4'(i), 4'(15 - i), (i % 2 == 0), 1'b1);
        end
        chk("sat.cnt2", 32'(toggle_cnt2), 32'd3);
        chk("sat.cnt8", 32'(toggle_cnt), 32'd5);
        step("sat_hold", 4'd0, 4'd0, 1'b0, 1'b1);
        chk("sat.cnt2_stay", 32'(toggle_cnt2), 32'd3);

        // randomised traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                mid_reset("rnd_rst");
            end else begin
                step("rnd", 4'($urandom), 4'($urandom), 1'($urandom),
                     ($urandom_range(0, 3) != 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mux2_4_new
